// File: rtl/core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : core_issue_ctrl
// Brief   : Operand FIFO and pulse-protocol issue/capture controller for one
//           core, with a watchdog that substitutes a marker word on timeout.
// Revision: 1.0 - initial release
// ============================================================================
module core_issue_ctrl #(
   parameter int          DEPTH        = 4,
   parameter int          TIMEOUT      = 16,
   parameter logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [31:0]              core_data_in,
   output logic                     core_valid_in,
   input  logic [31:0]              core_data_out,
   input  logic                     core_valid_out,
   output logic [31:0]              res_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     res_timeout,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     err_stray
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
   localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [31:0]         r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_WD_W-1:0]   r_wdog;
   logic [31:0]         r_op;
   logic [31:0]         r_res;
   logic                r_res_to;
   logic                r_err;
   logic                w_push;
   logic                w_pop;
   logic                w_issue;
   logic                w_cap;
   logic                w_tmo;
   logic                w_res_valid;

   // Ready comes from the registered count, so a full FIFO never accepts.
   assign in_ready = (r_count != c_FULL);
   assign w_push   = in_valid && in_ready;

   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_issue     = 1'b0;
      w_cap       = 1'b0;
      w_tmo       = 1'b0;
      w_res_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_issue = 1'b1;
            w_next  = S_WAIT;
         end
         S_WAIT: begin
            // A pulse in the final watchdog cycle still beats the timeout.
            if (core_valid_out) begin
               w_cap  = 1'b1;
               w_next = S_OUT;
            end else if (r_wdog == c_WD_LAST) begin
               w_tmo  = 1'b1;
               w_next = S_OUT;
            end
         end
         S_OUT: begin
            w_res_valid = 1'b1;
            if (res_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wdog   <= '0;
         r_op     <= '0;
         r_res    <= '0;
         r_res_to <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_op     <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_issue) begin
            r_wdog <= '0;
         end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + c_WD_W'(1);
         end
         if (w_cap) begin
            r_res    <= core_data_out;
            r_res_to <= 1'b0;
         end else if (w_tmo) begin
            r_res    <= TIMEOUT_WORD;
            r_res_to <= 1'b1;
         end
         if (core_valid_out && (r_state != S_WAIT)) begin
            r_err <= 1'b1;
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   assign core_data_in  = r_op;
   assign core_valid_in = w_issue;
   assign res_data      = r_res;
   assign res_timeout   = r_res_to;
   assign res_valid     = w_res_valid;
   assign fifo_count    = r_count;
   assign err_stray     = r_err;
   assign busy          = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_issue_ctrl
// Brief   : Scoreboard bench for core_issue_ctrl with a behavioural core model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_issue_ctrl;

   localparam int          DEPTH = 4;
   localparam int          TO    = 16;
   localparam logic [31:0] TOW   = 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] data;
      logic        tmo;
   } res_t;

   logic                  clk;
   logic                  reset_n;
   logic [31:0]           in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           core_data_in;
   logic                  core_valid_in;
   logic [31:0]           core_data_out;
   logic                  core_valid_out;
   logic                  core_pulse;
   logic                  stray_pulse;
   logic [31:0]           res_data;
   logic                  res_valid;
   logic                  res_ready;
   logic                  res_timeout;
   logic                  busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  err_stray;

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   max_cnt = 0;
   bit   rv_prev = 1'b0;

   res_t        exp_q[$];
   logic [31:0] op_q[$];
   int          dly_q[$];
   int          psh_q[$];
   int          iss_q[$];
   int          rv_q[$];

   assign core_valid_out = core_pulse | stray_pulse;

   core_issue_ctrl #(
      .DEPTH        (DEPTH),
      .TIMEOUT      (TO),
      .TIMEOUT_WORD (TOW)
   ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .core_data_in   (core_data_in),
      .core_valid_in  (core_valid_in),
      .core_data_out  (core_data_out),
      .core_valid_out (core_valid_out),
      .res_data       (res_data),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_timeout    (res_timeout),
      .busy           (busy),
      .fifo_count     (fifo_count),
      .err_stray      (err_stray)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_in_ready"},   in_ready,      1);
      chk({pfx, "_fifo_count"}, fifo_count,    0);
      chk({pfx, "_busy"},       busy,          0);
      chk({pfx, "_res_valid"},  res_valid,     0);
      chk({pfx, "_vin"},        core_valid_in, 0);
      chk({pfx, "_din"},        core_data_in,  0);
      chk({pfx, "_res_data"},   res_data,      0);
      chk({pfx, "_res_tmo"},    res_timeout,   0);
      chk({pfx, "_err_stray"},  err_stray,     0);
   endtask

   // Core answers d cycles after the issue pulse (d==0: never; d>TO: too late).
   task automatic push_word(input logic [31:0] w, input int d);
      int n = 0;
      in_data  = w;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", in_ready, 1);
      psh_q.push_back(cyc);
      op_q.push_back(w);
      dly_q.push_back(d);
      if (d == 0 || d > TO) exp_q.push_back('{TOW, 1'b1});
      else                  exp_q.push_back('{{16'h0000, w[31:16] & w[15:0]}, 1'b0});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      psh_q.delete();
      iss_q.delete();
      rv_q.delete();
   endtask

   // Core model: checks issued operand order and hold, replies with A & B.
   initial begin
      core_pulse    = 1'b0;
      core_data_out = '0;
      forever begin
         @(negedge clk);
         if (reset_n && core_valid_in) begin
            logic [31:0] op;
            int d;
            op = core_data_in;
            iss_q.push_back(cyc);
            if (op_q.size() > 0) chk("issue_op", op, op_q.pop_front());
            if (dly_q.size() > 0) d = dly_q.pop_front();
            else                  d = 0;
            @(negedge clk);
            chk("hold_data", core_data_in, op);
            chk("vin_single", core_valid_in, 0);
            if (d > 0) begin
               repeat (d - 1) @(posedge clk);
               #1;
               core_pulse    = 1'b1;
               core_data_out = {16'h0000, op[31:16] & op[15:0]};
               @(posedge clk);
               #1 core_pulse = 1'b0;
            end
         end
      end
   end

   // Result monitor / scoreboard consumer.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && res_valid && !rv_prev) rv_q.push_back(cyc);
         rv_prev = res_valid;
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", res_valid, 0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_tmo", res_timeout, e.tmo);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      res_ready   = 1'b0;
      stray_pulse = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b1;

      // Single op latency
      clear_logs();
      push_word(32'hFF0F_0F0F, 3);
      wait_drain(100);
      chk("lat_issue", iss_q[0], psh_q[0] + 2);
      chk("lat_res",   rv_q[0],  psh_q[0] + 6);

      // Back-to-back period
      clear_logs();
      push_word(32'h1234_FFFF, 3);
      push_word(32'hAAAA_5555, 3);
      wait_drain(100);
      chk("b2b_issue_period", iss_q[1] - iss_q[0], 6);
      chk("b2b_res_period",   rv_q[1]  - rv_q[0],  6);

      // Fill and backpressure
      res_ready = 1'b0;
      max_cnt   = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) push_word($urandom, 3);
         end
         begin
            repeat (25) @(posedge clk);
            #1;
            chk("full_in_ready", in_ready, 0);
            chk("full_count", fifo_count, DEPTH);
            chk("full_res_valid", res_valid, 1);
            res_ready = 1'b1;
         end
      join
      wait_drain(300);
      chk("max_count", max_cnt, DEPTH);

      // Watchdog timeout, then a normal op
      clear_logs();
      push_word(32'hCAFE_F00D, 0);
      push_word(32'h00FF_00F0, 3);
      wait_drain(200);
      chk("to_latency", rv_q[0] - iss_q[0], TO + 1);
      chk("to_next_issued", iss_q.size(), 2);

      // Pulse in the last WAIT cycle wins
      clear_logs();
      push_word(32'h5A5A_FFFF, TO);
      wait_drain(200);
      chk("edge_latency", rv_q[0] - iss_q[0], TO + 1);

      // Stray pulse while idle
      chk("stray_pre", err_stray, 0);
      stray_pulse = 1'b1;
      @(posedge clk);
      #1 stray_pulse = 1'b0;
      @(negedge clk);
      chk("stray_set", err_stray, 1);
      chk("stray_busy", busy, 0);
      chk("stray_res_valid", res_valid, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("stray_sticky", err_stray, 1);

      // Reset while waiting on the core with two words queued
      clear_logs();
      push_word(32'h1111_2222, 0);
      push_word(32'h3333_4444, 3);
      push_word(32'h5555_6666, 3);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_count", fifo_count, 2);
      reset_n = 1'b0;
      exp_q.delete();
      op_q.delete();
      dly_q.delete();
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      rv_q.delete();
      repeat (30) @(posedge clk);
      #1;
      chk("no_res_after_rst", rv_q.size(), 0);
      push_word(32'h0F0F_FFFF, 3);
      wait_drain(100);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
